// File: rtl/game_state_pkg.sv
// Shared game-state definitions for the Frogger sequencer, renderer and score display.
package game_state_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAYING   = 3'd1,
        ST_DYING     = 3'd2,
        ST_RESPAWN   = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_WIN       = 3'd5
    } game_state_t;

    localparam logic [6:0] c_SCORE_MAX = 7'd99;

    function automatic logic [6:0] score_inc(input logic [6:0] score);
        return (score >= c_SCORE_MAX) ? c_SCORE_MAX : score + 7'd1;
    endfunction

endpackage

// File: rtl/game_state_ctrl_button_debounce.sv
// Two-flop synchroniser followed by a stability counter; outputs the debounced button level.
module button_debounce #(
    parameter int c_DEBOUNCE_LIMIT = 250000
) (
    input  logic clk,
    input  logic srst,
    input  logic button,
    output logic level
);

    localparam int CW = $clog2(c_DEBOUNCE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_CNT = CW'(c_DEBOUNCE_LIMIT);

    logic [1:0]    sync_reg;
    logic [CW-1:0] count_reg;
    logic          level_reg;

    // The counter only runs while the synchronised input disagrees with the
    // debounced level; any bounce back to agreement restarts the wait.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg  <= 2'b00;
            count_reg <= '0;
            level_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], button};
            if (sync_reg[1] == level_reg) begin
                count_reg <= '0;
            end else if (count_reg == LIMIT_CNT) begin
                level_reg <= sync_reg[1];
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;

endmodule

// File: rtl/game_state_ctrl.sv
// Frogger game sequencer: start debounce, frame tick, game FSM, lives and score.
module game_state_ctrl
    import game_state_pkg::*;
#(
    parameter int c_LIVES          = 3,
    parameter int c_WIN_SCORE      = 5,
    parameter int c_DEATH_FRAMES   = 60,
    parameter int c_DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_VSync,
    input  logic       i_Game_Start,
    input  logic       i_Collided,
    input  logic       i_Goal_Reached,
    output logic       o_Game_Active,
    output logic       o_Respawn,
    output logic [1:0] o_Lives,
    output logic [6:0] o_Score,
    output logic [2:0] o_State,
    output logic       o_Game_Over,
    output logic       o_Win
);

    localparam logic [1:0] LIVES_INIT  = 2'(c_LIVES);
    localparam logic [6:0] WIN_SCORE   = 7'(c_WIN_SCORE);
    localparam logic [7:0] DEATH_INIT  = 8'(c_DEATH_FRAMES);

    game_state_t state_reg, state_next;
    logic [1:0]  lives_reg, lives_next;
    logic [6:0]  score_reg, score_next;
    logic [7:0]  frame_cnt_reg, frame_cnt_next;
    logic        vsync_reg;
    logic        collided_prev_reg;
    logic        start_prev_reg;
    logic        start_level;
    logic        start_pulse;
    logic        frame_tick;
    logic        coll_rise;
    logic [6:0]  score_inc_val;

    button_debounce #(
        .c_DEBOUNCE_LIMIT(c_DEBOUNCE_LIMIT)
    ) u_start_debounce (
        .clk    (i_Clk),
        .srst   (i_Reset),
        .button (i_Game_Start),
        .level  (start_level)
    );

    assign start_pulse = start_level & ~start_prev_reg;
    assign frame_tick  = vsync_reg & ~i_VSync;
    assign coll_rise   = i_Collided & ~collided_prev_reg;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_reg         <= ST_IDLE;
            lives_reg         <= LIVES_INIT;
            score_reg         <= 7'd0;
            frame_cnt_reg     <= 8'd0;
            vsync_reg         <= 1'b0;
            collided_prev_reg <= 1'b0;
            start_prev_reg    <= 1'b0;
        end else begin
            state_reg         <= state_next;
            lives_reg         <= lives_next;
            score_reg         <= score_next;
            frame_cnt_reg     <= frame_cnt_next;
            vsync_reg         <= i_VSync;
            collided_prev_reg <= i_Collided;
            start_prev_reg    <= start_level;
        end
    end

    always_comb begin
        state_next     = state_reg;
        lives_next     = lives_reg;
        score_next     = score_reg;
        frame_cnt_next = frame_cnt_reg;
        score_inc_val  = score_inc(score_reg);

        case (state_reg)
            ST_IDLE: begin
                lives_next = LIVES_INIT;
                score_next = 7'd0;
                if (start_pulse) begin
                    state_next = ST_RESPAWN;
                end
            end
            ST_PLAYING: begin
                // A collision in the same cycle as a goal takes priority; the goal is lost.
                if (coll_rise) begin
                    lives_next     = lives_reg - 2'd1;
                    frame_cnt_next = DEATH_INIT;
                    state_next     = ST_DYING;
                end else if (i_Goal_Reached) begin
                    score_next = score_inc_val;
                    state_next = (score_inc_val == WIN_SCORE) ? ST_WIN : ST_RESPAWN;
                end
            end
            ST_DYING: begin
                if (frame_cnt_reg == 8'd0) begin
                    state_next = (lives_reg == 2'd0) ? ST_GAME_OVER : ST_RESPAWN;
                end else if (frame_tick) begin
                    frame_cnt_next = frame_cnt_reg - 8'd1;
                end
            end
            ST_RESPAWN: begin
                state_next = ST_PLAYING;
            end
            ST_GAME_OVER, ST_WIN: begin
                if (start_pulse) begin
                    lives_next = LIVES_INIT;
                    score_next = 7'd0;
                    state_next = ST_RESPAWN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_State       = state_reg;
    assign o_Game_Active = (state_reg == ST_PLAYING);
    assign o_Respawn     = (state_reg == ST_RESPAWN);
    assign o_Game_Over   = (state_reg == ST_GAME_OVER);
    assign o_Win         = (state_reg == ST_WIN);
    assign o_Lives       = lives_reg;
    assign o_Score       = score_reg;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with short debounce, two death frames and a two-goal win.
module tb_game_state_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       vsync;
    logic       start;
    logic       collided;
    logic       goal;
    logic       game_active;
    logic       respawn;
    logic [1:0] lives;
    logic [6:0] score;
    logic [2:0] state;
    logic       game_over;
    logic       win;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] S_IDLE = 0, S_PLAY = 1, S_DYING = 2, S_RESP = 3, S_GO = 4, S_WIN = 5;

    always #5 clk = ~clk;

    game_state_ctrl #(
        .c_LIVES          (3),
        .c_WIN_SCORE      (2),
        .c_DEATH_FRAMES   (2),
        .c_DEBOUNCE_LIMIT (4)
    ) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_VSync        (vsync),
        .i_Game_Start   (start),
        .i_Collided     (collided),
        .i_Goal_Reached (goal),
        .o_Game_Active  (game_active),
        .o_Respawn      (respawn),
        .o_Lives        (lives),
        .o_Score        (score),
        .o_State        (state),
        .o_Game_Over    (game_over),
        .o_Win          (win)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One VSync low pulse lasting one clock: exactly one frame tick.
    task automatic frame();
        vsync = 1'b0;
        step(1);
        vsync = 1'b1;
        step(1);
    endtask

    // Release then re-press the button; returns 7 edges after the press, one edge before RESPAWN.
    task automatic repress();
        start = 1'b0;
        step(8);
        start = 1'b1;
        step(7);
    endtask

    task automatic death(input logic [31:0] lives_exp, input logic [31:0] final_state);
        collided = 1'b1;
        step(1);
        $display("txn: collision, lives now %0d", lives);
        check("death_state", 32'(state), S_DYING);
        check("death_lives", 32'(lives), lives_exp);
        check("death_active", 32'(game_active), 0);
        collided = 1'b0;
        frame();
        check("death_hold_state", 32'(state), S_DYING);
        check("death_hold_active", 32'(game_active), 0);
        frame();
        check("death_exit_state", 32'(state), final_state);
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b1; start = 1'b0; collided = 1'b0; goal = 1'b0;
        step(2);
        $display("txn: reset");
        check("rst_state", 32'(state), S_IDLE);
        check("rst_lives", 32'(lives), 3);
        check("rst_score", 32'(score), 0);
        check("rst_active", 32'(game_active), 0);
        check("rst_respawn", 32'(respawn), 0);
        check("rst_game_over", 32'(game_over), 0);
        check("rst_win", 32'(win), 0);
        rst = 1'b0;
        step(1);

        // Two-cycle glitch never survives the stability counter.
        start = 1'b1;
        step(2);
        start = 1'b0;
        step(12);
        $display("txn: start glitch");
        check("glitch_state", 32'(state), S_IDLE);

        start = 1'b1;
        step(7);
        check("start_early_state", 32'(state), S_IDLE);
        step(1);
        $display("txn: start press");
        check("start_state", 32'(state), S_RESP);
        check("start_respawn", 32'(respawn), 1);
        check("start_lives", 32'(lives), 3);
        check("start_score", 32'(score), 0);
        step(1);
        check("play_state", 32'(state), S_PLAY);
        check("play_respawn", 32'(respawn), 0);
        check("play_active", 32'(game_active), 1);

        death(2, S_RESP);
        check("d1_respawn", 32'(respawn), 1);
        step(1);
        check("d1_play", 32'(state), S_PLAY);
        death(1, S_RESP);
        step(1);
        check("d2_play", 32'(state), S_PLAY);
        death(0, S_GO);
        check("d3_game_over", 32'(game_over), 1);
        step(3);
        check("go_hold_state", 32'(state), S_GO);
        check("go_hold_lives", 32'(lives), 0);

        repress();
        check("go_wait_state", 32'(state), S_GO);
        step(1);
        $display("txn: restart from game over");
        check("go_restart_state", 32'(state), S_RESP);
        check("go_restart_lives", 32'(lives), 3);
        step(1);

        goal = 1'b1;
        step(1);
        goal = 1'b0;
        $display("txn: goal 1, score %0d", score);
        check("goal1_score", 32'(score), 1);
        check("goal1_state", 32'(state), S_RESP);
        check("goal1_respawn", 32'(respawn), 1);
        step(1);
        check("goal1_play", 32'(state), S_PLAY);
        goal = 1'b1;
        step(1);
        goal = 1'b0;
        $display("txn: goal 2, score %0d", score);
        check("goal2_score", 32'(score), 2);
        check("goal2_state", 32'(state), S_WIN);
        check("goal2_win", 32'(win), 1);
        check("goal2_active", 32'(game_active), 0);
        step(3);
        check("win_hold_score", 32'(score), 2);
        check("win_hold_win", 32'(win), 1);

        repress();
        check("win_wait_state", 32'(state), S_WIN);
        step(1);
        $display("txn: restart from win");
        check("win_restart_state", 32'(state), S_RESP);
        check("win_restart_lives", 32'(lives), 3);
        check("win_restart_score", 32'(score), 0);
        check("win_restart_win", 32'(win), 0);
        step(1);

        goal = 1'b1;
        collided = 1'b1;
        step(1);
        goal = 1'b0;
        $display("txn: goal and collision together");
        check("both_state", 32'(state), S_DYING);
        check("both_score", 32'(score), 0);
        check("both_lives", 32'(lives), 2);

        goal = 1'b1;
        step(1);
        goal = 1'b0;
        check("dying_goal_score", 32'(score), 0);
        check("dying_goal_state", 32'(state), S_DYING);
        repress();
        step(3);
        $display("txn: start press while dying");
        check("dying_start_state", 32'(state), S_DYING);
        check("dying_start_lives", 32'(lives), 2);

        frame();
        frame();
        check("held_coll_state", 32'(state), S_RESP);
        check("held_coll_lives", 32'(lives), 2);
        step(3);
        check("held_coll_play", 32'(state), S_PLAY);
        check("held_coll_lives2", 32'(lives), 2);
        collided = 1'b0;
        step(1);

        goal = 1'b1;
        step(1);
        goal = 1'b0;
        step(1);
        check("pre_reset_score", 32'(score), 1);
        collided = 1'b1;
        step(1);
        check("pre_reset_state", 32'(state), S_DYING);
        check("pre_reset_lives", 32'(lives), 1);
        start = 1'b0;
        rst = 1'b1;
        step(1);
        $display("txn: reset while dying");
        check("mid_rst_state", 32'(state), S_IDLE);
        check("mid_rst_lives", 32'(lives), 3);
        check("mid_rst_score", 32'(score), 0);
        check("mid_rst_respawn", 32'(respawn), 0);
        check("mid_rst_active", 32'(game_active), 0);
        check("mid_rst_game_over", 32'(game_over), 0);
        check("mid_rst_win", 32'(win), 0);
        rst = 1'b0;
        collided = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Top-level game sequencer for Frogger. It sits upstream of the frame renderer and frog controller, and replaces the hard-wired "game active" tie-off. It debounces the start button and derives a per-frame tick from VSync. It runs the IDLE/PLAYING/DYING/RESPAWN/GAME_OVER/WIN state machine and owns the lives counter and score, so every consumer sees one consistent game state.

## Interface

Parameters:
- c_LIVES, 3 — lives at game start; legal range 1..3.
- c_WIN_SCORE, 5 — goals needed to win; legal range 1..99.
- c_DEATH_FRAMES, 60 — frames frozen in DYING; legal range 1..255.
- c_DEBOUNCE_LIMIT, 250000 — clocks the start button must be stable (10 ms at 25 MHz).

Ports:
- i_Clk  in  1  — pixel clock; the only clock.
- i_Reset  in  1  — synchronous, active-high reset.
- i_VSync  in  1  — VSync from the sync stage, active low.
- i_Game_Start  in  1  — raw start button.
- i_Collided  in  1  — level signal from the collision checker.
- i_Goal_Reached  in  1  — 1-cycle pulse when the frog lands on a lily pad.
- o_Game_Active  out  1  — high only in PLAYING.
- o_Respawn  out  1  — 1-cycle pulse that tells the frog controller to return the frog to its origin.
- o_Lives  out  2  — remaining lives.
- o_Score  out  7  — goals scored, 0..99.
- o_State  out  3  — current state encoding.
- o_Game_Over  out  1  — high in GAME_OVER.
- o_Win  out  1  — high in WIN.

## Operation

- Start button: synchronised through 2 flops, then debounced; the debounced rising edge gives start_pulse, 1 cycle wide.
- Frame tick: registered i_VSync; a 1→0 transition gives frame_tick, 1 cycle wide.
- Collision edge: coll_rise = i_Collided & ~r_Collided_Prev. r_Collided_Prev updates every cycle in every state.
- IDLE:
  - Outputs: lives = c_LIVES, score = 0.
  - start_pulse → RESPAWN.
- PLAYING:
  - coll_rise: lives ← lives−1, frame counter ← c_DEATH_FRAMES, → DYING.
  - Else i_Goal_Reached: score ← score+1, saturating at 99.
    - New score = c_WIN_SCORE → WIN.
    - Otherwise → RESPAWN.
  - coll_rise and goal in the same cycle: collision wins; the goal is dropped and score is unchanged.
- DYING:
  - Each frame_tick decrements the counter.
  - Counter at 0 and lives = 0 → GAME_OVER.
  - Counter at 0 and lives > 0 → RESPAWN.
  - i_Collided and i_Goal_Reached are ignored.
- RESPAWN: exactly one cycle; o_Respawn = 1; → PLAYING.
- GAME_OVER and WIN:
  - Hold all outputs.
  - start_pulse: lives ← c_LIVES, score ← 0, → RESPAWN.
- start_pulse is ignored in PLAYING, DYING and RESPAWN.
- Lives never underflow; a decrement at 0 is impossible by construction.
- Arithmetic:
  - Score is a 7-bit unsigned saturating increment.
  - The frame counter is 8-bit unsigned.
  - The debounce counter is sized as $clog2(c_DEBOUNCE_LIMIT+1).

## Timing

- All state and counters are registered. Outputs decode from registers, so there are no combinational paths from input to output.
- Reset values:
  - State = IDLE, o_State = 0.
  - o_Game_Active = 0, o_Respawn = 0, o_Game_Over = 0, o_Win = 0.
  - o_Lives = c_LIVES, o_Score = 0.
  - All counters and edge registers = 0.
- Reset asserted mid-game forces IDLE at the next edge regardless of state.
- Latencies:
  - coll_rise at edge k: o_Game_Active low and o_Lives decremented after edge k (1 clock).
  - Goal at edge k: o_Score updated and o_Respawn high for the cycle after edge k.
  - Button edge to start_pulse: 2 sync + c_DEBOUNCE_LIMIT + 1 clocks.
- DYING lasts c_DEATH_FRAMES frame ticks plus up to 1 frame of phase.

## Structure

- Package game_state_pkg:
  - State encoding: IDLE = 0, PLAYING = 1, DYING = 2, RESPAWN = 3, GAME_OVER = 4, WIN = 5.
  - Constant c_SCORE_MAX = 99.
  - Shared by the renderer and the score display.
- Sub-module button_debounce (parameter c_DEBOUNCE_LIMIT): 2-flop synchroniser plus stable counter; outputs the debounced level. The edge detect stays in the parent.
- Parent holds the FSM, lives/score registers, frame tick and frame counter.

## Test plan

- **Reset/start:** reset, then press start with c_DEBOUNCE_LIMIT = 4.
  - States: IDLE → RESPAWN (o_Respawn = 1 for exactly 1 cycle) → PLAYING.
  - o_Lives = 3, o_Score = 0.
  - A 2-cycle glitch on the button produces no start_pulse.
- **Three deaths (c_DEATH_FRAMES = 2):** raise i_Collided three times, each time after returning to PLAYING.
  - o_Lives steps 2, 1, 0.
  - Each death holds o_Game_Active low for 2 frame ticks.
  - After the third death, the state goes to GAME_OVER with o_Game_Over = 1.
- **Win (c_WIN_SCORE = 2):** two goal pulses.
  - First pulse: o_Score = 1 and a respawn pulse.
  - Second pulse: o_Score = 2 and WIN with o_Win = 1.
  - A start_pulse from WIN restores lives = 3, score = 0 and goes to RESPAWN.
- **Simultaneous goal and collision:** both in the same cycle.
  - Score is unchanged, lives decrement, state → DYING.
  - Collision held high through DYING and RESPAWN causes no second decrement.
- **Reset mid-DYING:** assert i_Reset.
  - Next edge: IDLE, lives = c_LIVES, score = 0, all pulses low.
- **Ignored inputs:** in DYING, a goal pulse and a start_pulse change nothing.
